// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table during hblank,
// fetches pattern rows for up to SLOTS visible sprites, commits at line start.
module sprite_line_scheduler #(
    parameter int NSPR  = 32,
    parameter int SLOTS = 8,
    localparam int AW   = $clog2(NSPR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hblank_start,
    input  logic                  line_start,
    input  logic                  vsync,
    input  logic [8:0]            next_line,
    output logic [AW-1:0]         attr_addr,
    input  logic [31:0]           attr_data,
    output logic [10:0]           pat_addr,
    input  logic [31:0]           pat_data,
    output logic [SLOTS-1:0]      slot_valid,
    output logic [9*SLOTS-1:0]    slot_posX,
    output logic [4*SLOTS-1:0]    slot_sclX,
    output logic [SLOTS-1:0]      slot_swpX,
    output logic [32*SLOTS-1:0]   slot_colors,
    output logic                  busy,
    output logic                  overflow,
    output logic                  late
);

    localparam int CW = $clog2(SLOTS + 1);

    typedef enum logic [2:0] {IDLE, ATTR, EVAL, PAT, STORE, DONE} state_t;

    state_t state_q, state_d;

    logic [AW-1:0]        idx_q;
    logic [CW-1:0]        cnt_q;
    logic [8:0]           line_q;
    logic [AW-1:0]        attr_addr_q;
    logic [10:0]          pat_addr_q;
    logic [8:0]           lpos_q;
    logic [3:0]           lscl_q;
    logic                 lswp_q;
    logic [6:0]           lpat_q;
    logic [3:0]           row4_q;
    logic                 ovf_q;
    logic                 late_q;

    logic [SLOTS-1:0]     sh_v_q,   act_v_q;
    logic [9*SLOTS-1:0]   sh_px_q,  act_px_q;
    logic [4*SLOTS-1:0]   sh_sc_q,  act_sc_q;
    logic [SLOTS-1:0]     sh_sw_q,  act_sw_q;
    logic [32*SLOTS-1:0]  sh_col_q, act_col_q;

    logic [8:0]  row9;
    logic [3:0]  row4;
    logic        hit, room, last, busy_w, start;
    logic        latch, store, idx_inc, ovf_set, late_set;

    assign row9   = line_q - attr_data[17:9];
    assign row4   = attr_data[19] ? ~row9[3:0] : row9[3:0];
    assign hit    = attr_data[20] && (row9[8:4] == 5'd0);
    assign room   = cnt_q < CW'(SLOTS);
    assign last   = idx_q == AW'(NSPR - 1);
    assign busy_w = (state_q == ATTR) || (state_q == EVAL) ||
                    (state_q == PAT)  || (state_q == STORE);
    // A coincident line_start frees the FSM, so hblank_start is accepted too.
    assign start    = hblank_start && (line_start || !busy_w);
    assign late_set = line_start && busy_w;

    assign attr_addr = (state_q == ATTR) ? idx_q : attr_addr_q;
    assign pat_addr  = (state_q == PAT) ? {lpat_q, row4_q} : pat_addr_q;

    assign slot_valid  = act_v_q;
    assign slot_posX   = act_px_q;
    assign slot_sclX   = act_sc_q;
    assign slot_swpX   = act_sw_q;
    assign slot_colors = act_col_q;
    assign busy        = busy_w;
    assign overflow    = ovf_q;
    assign late        = late_q;

    // Scan sequencing; line_start aborts the scan, a new hblank restarts it.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        store   = 1'b0;
        idx_inc = 1'b0;
        ovf_set = 1'b0;
        unique case (state_q)
            IDLE, DONE: state_d = state_q;
            ATTR:       state_d = EVAL;
            EVAL: begin
                if (hit && room) begin
                    latch   = 1'b1;
                    state_d = PAT;
                end else if (hit) begin
                    ovf_set = 1'b1;
                    state_d = DONE;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    idx_inc = 1'b1;
                    state_d = ATTR;
                end
            end
            PAT:        state_d = STORE;
            STORE: begin
                store = 1'b1;
                if (last) begin
                    state_d = DONE;
                end else begin
                    idx_inc = 1'b1;
                    state_d = ATTR;
                end
            end
            default:    state_d = IDLE;
        endcase
        if (line_start) begin
            state_d = IDLE;
            latch   = 1'b0;
            store   = 1'b0;
            idx_inc = 1'b0;
            ovf_set = 1'b0;
        end
        if (start) begin
            state_d = ATTR;
        end
    end

    // State, scan counters, fetch latches, shadow and active slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            line_q      <= '0;
            attr_addr_q <= '0;
            pat_addr_q  <= '0;
            lpos_q      <= '0;
            lscl_q      <= '0;
            lswp_q      <= 1'b0;
            lpat_q      <= '0;
            row4_q      <= '0;
            ovf_q       <= 1'b0;
            late_q      <= 1'b0;
            sh_v_q      <= '0;
            sh_px_q     <= '0;
            sh_sc_q     <= '0;
            sh_sw_q     <= '0;
            sh_col_q    <= '0;
            act_v_q     <= '0;
            act_px_q    <= '0;
            act_sc_q    <= '0;
            act_sw_q    <= '0;
            act_col_q   <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= (ovf_q & ~vsync) | ovf_set;
            late_q  <= (late_q & ~vsync) | late_set;
            if (state_q == ATTR) begin
                attr_addr_q <= idx_q;
            end
            if (state_q == PAT) begin
                pat_addr_q <= {lpat_q, row4_q};
            end
            if (latch) begin
                lpos_q <= attr_data[8:0];
                lscl_q <= attr_data[31:28];
                lswp_q <= attr_data[18];
                lpat_q <= attr_data[27:21];
                row4_q <= row4;
            end
            if (line_start) begin
                act_v_q   <= sh_v_q;
                act_px_q  <= sh_px_q;
                act_sc_q  <= sh_sc_q;
                act_sw_q  <= sh_sw_q;
                act_col_q <= sh_col_q;
            end
            if (start) begin
                line_q <= next_line;
                idx_q  <= '0;
                cnt_q  <= '0;
                sh_v_q <= '0;
            end else begin
                if (idx_inc) begin
                    idx_q <= idx_q + AW'(1);
                end
                if (store) begin
                    cnt_q <= cnt_q + CW'(1);
                end
                for (int k = 0; k < SLOTS; k++) begin
                    if (store && (cnt_q == CW'(k))) begin
                        sh_v_q[k]            <= 1'b1;
                        sh_px_q[9*k +: 9]    <= lpos_q;
                        sh_sc_q[4*k +: 4]    <= lscl_q;
                        sh_sw_q[k]           <= lswp_q;
                        sh_col_q[32*k +: 32] <= pat_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: a line-level reference model
// predicts the committed slots and flags for each scanned line.
module tb_sprite_line_scheduler;

    localparam int NSPR  = 32;
    localparam int SLOTS = 8;
    localparam int AW    = $clog2(NSPR);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 hblank_start, line_start, vsync;
    logic [8:0]           next_line;
    logic [AW-1:0]        attr_addr;
    logic [31:0]          attr_data;
    logic [10:0]          pat_addr;
    logic [31:0]          pat_data;
    logic [SLOTS-1:0]     slot_valid;
    logic [9*SLOTS-1:0]   slot_posX;
    logic [4*SLOTS-1:0]   slot_sclX;
    logic [SLOTS-1:0]     slot_swpX;
    logic [32*SLOTS-1:0]  slot_colors;
    logic                 busy, overflow, late;

    logic [31:0] attr_mem [NSPR];
    logic [31:0] pat_mem  [2048];

    typedef struct {
        logic [SLOTS-1:0]    v;
        logic [9*SLOTS-1:0]  px;
        logic [4*SLOTS-1:0]  sc;
        logic [SLOTS-1:0]    sw;
        logic [32*SLOTS-1:0] col;
        logic                late;
        logic                ovf;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   cur_line = 0;

    sprite_line_scheduler #(.NSPR(NSPR), .SLOTS(SLOTS)) dut (
        .clk(clk), .rst(rst),
        .hblank_start(hblank_start), .line_start(line_start),
        .vsync(vsync), .next_line(next_line),
        .attr_addr(attr_addr), .attr_data(attr_data),
        .pat_addr(pat_addr), .pat_data(pat_data),
        .slot_valid(slot_valid), .slot_posX(slot_posX),
        .slot_sclX(slot_sclX), .slot_swpX(slot_swpX),
        .slot_colors(slot_colors), .busy(busy),
        .overflow(overflow), .late(late)
    );

    always #5 clk = ~clk;

    // Synchronous attribute and pattern memories (one-cycle read latency).
    always @(posedge clk) begin
        attr_data <= attr_mem[attr_addr];
        pat_data  <= pat_mem[pat_addr];
    end

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int px, input int py,
                                       input int sx, input int sy,
                                       input int en, input int pat,
                                       input int scl);
        mk = {scl[3:0], pat[6:0], en[0], sy[0], sx[0], py[8:0], px[8:0]};
    endfunction

    // Line-level model: walk entries in order, charging 2 cycles per miss
    // and 4 per hit; a slot is committed only if its store edge precedes
    // the line_start edge L (edges counted from the hblank_start edge).
    function automatic exp_t model(input int line, input int L);
        exp_t        e;
        int          h, t, dn;
        bit          ovf;
        logic [31:0] a;
        logic [8:0]  r9, ln;
        logic [3:0]  r4;
        e.v = '0; e.px = '0; e.sc = '0; e.sw = '0; e.col = '0;
        h = 0; t = 0; dn = -1; ovf = 0;
        ln = line[8:0];
        for (int i = 0; i < NSPR; i++) begin
            a  = attr_mem[i];
            r9 = ln - a[17:9];
            if (a[20] && r9 < 9'd16) begin
                if (h == SLOTS) begin
                    ovf = 1;
                    dn  = t + 2;
                    break;
                end
                if (t + 4 < L) begin
                    r4 = a[19] ? ~r9[3:0] : r9[3:0];
                    e.v[h]            = 1'b1;
                    e.px[9*h +: 9]    = a[8:0];
                    e.sc[4*h +: 4]    = a[31:28];
                    e.sw[h]           = a[18];
                    e.col[32*h +: 32] = pat_mem[{a[27:21], r4}];
                end
                h++;
                t += 4;
            end else begin
                t += 2;
            end
        end
        if (dn < 0) dn = t;
        e.late = (L <= dn);
        e.ovf  = ovf && (L > dn);
        return e;
    endfunction

    // Monitor: every committing line_start pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (line_start && !rst) begin
                @(negedge clk);
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty got=commit want=none");
                end else begin
                    e = sbq.pop_front();
                    chk("slot_valid", 512'(slot_valid), 512'(e.v));
                    chk("late", 512'(late), 512'(e.late));
                    chk("overflow", 512'(overflow), 512'(e.ovf));
                    for (int k = 0; k < SLOTS; k++) begin
                        if (e.v[k]) begin
                            chk($sformatf("slot%0d", k),
                                512'({slot_posX[9*k +: 9], slot_sclX[4*k +: 4],
                                      slot_swpX[k], slot_colors[32*k +: 32]}),
                                512'({e.px[9*k +: 9], e.sc[4*k +: 4],
                                      e.sw[k], e.col[32*k +: 32]}));
                        end
                    end
                end
            end
        end
    end

    task automatic adv();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) adv();
    endtask

    task automatic hb(input int line);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync        = 1'b0;
        next_line    = line[8:0];
        hblank_start = 1'b1;
        @(negedge clk);
        hblank_start = 1'b0;
        cyc      = 0;
        cur_line = line;
    endtask

    task automatic commit(input int L);
        wait_to(L - 1);
        sbq.push_back(model(cur_line, L));
        line_start = 1'b1;
        adv();
        line_start = 1'b0;
    endtask

    task automatic clear_attr();
        for (int i = 0; i < NSPR; i++) attr_mem[i] = '0;
    endtask

    initial begin
        exp_t z;
        int   line, off;
        rst = 1'b1;
        hblank_start = 1'b0;
        line_start = 1'b0;
        vsync = 1'b0;
        next_line = '0;
        clear_attr();
        for (int i = 0; i < 2048; i++) pat_mem[i] = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_valid", 512'(slot_valid), 512'(0));
        chk("rst_posX", 512'(slot_posX), 512'(0));
        chk("rst_colors", 512'(slot_colors), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_flags", 512'({overflow, late}), 512'(0));
        chk("rst_addr", 512'({attr_addr, pat_addr}), 512'(0));
        rst = 1'b0;

        // Single sprite at entry 3.
        attr_mem[3] = mk(100, 20, 0, 0, 1, 5, 0);
        hb(25);
        commit(70);
        chk("single_pat_addr", 512'(pat_addr), 512'(11'h055));
        chk("single_posX", 512'(slot_posX[8:0]), 512'(100));
        chk("single_colors", 512'(slot_colors[31:0]), 512'(pat_mem[11'h055]));

        // Vertical flip.
        attr_mem[3] = mk(100, 20, 0, 1, 1, 5, 0);
        hb(20);
        commit(70);
        chk("swpy_pat_addr", 512'(pat_addr), 512'(11'h05F));

        // Overflow: ten sprites on line 0.
        clear_attr();
        for (int i = 0; i < 10; i++) attr_mem[i] = mk(i * 10, 0, i & 1, 0, 1, i, i);
        hb(0);
        wait_to(33);
        chk("ovf_busy33", 512'(busy), 512'(1));
        wait_to(34);
        chk("ovf_done34", 512'(busy), 512'(0));
        commit(40);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        chk("vsync_clear", 512'(overflow), 512'(0));

        // Late commit: only two stores complete.
        attr_mem[8] = '0;
        attr_mem[9] = '0;
        hb(0);
        commit(10);
        chk("late_flag", 512'(late), 512'(1));
        chk("late_valid", 512'(slot_valid), 512'(8'b0000_0011));
        chk("late_idle", 512'(busy), 512'(0));

        // Wrap boundary and disabled entry.
        clear_attr();
        attr_mem[0] = mk(7, 510, 1, 0, 1, 9, 3);
        attr_mem[1] = mk(30, 10, 0, 0, 0, 2, 1);
        hb(14);
        commit(80);
        chk("wrap_miss", 512'(slot_valid), 512'(0));
        hb(13);
        commit(80);
        chk("wrap_hit_addr", 512'(pat_addr), 512'({7'd9, 4'hF}));

        // Reset during PAT.
        clear_attr();
        attr_mem[0] = mk(50, 100, 0, 0, 1, 3, 2);
        hb(100);
        commit(80);
        hb(100);
        wait_to(2);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 512'(slot_valid), 512'(0));
        chk("rstmid_posX", 512'(slot_posX), 512'(0));
        chk("rstmid_busy", 512'(busy), 512'(0));
        chk("rstmid_pat_addr", 512'(pat_addr), 512'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        z.v = '0; z.px = '0; z.sc = '0; z.sw = '0; z.col = '0;
        z.late = 1'b0; z.ovf = 1'b0;
        sbq.push_back(z);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;

        // Randomized lines.
        for (int t = 0; t < 30; t++) begin
            line = $urandom_range(0, 511);
            for (int i = 0; i < NSPR; i++) begin
                off = $urandom_range(0, 40);
                attr_mem[i] = mk($urandom_range(0, 511), (line - off) & 511,
                                 $urandom_range(0, 1), $urandom_range(0, 1),
                                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                                 $urandom_range(0, 127), $urandom_range(0, 15));
            end
            hb(line);
            commit($urandom_range(10, 110));
            repeat (2) adv();
        end

        repeat (4) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover got=%0d want=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
